// File: rtl/aes_sbox_sched_pkg.sv
// Shared AES constants for the S-box scheduler: lane geometry, beat counter
// width and the sequencing state encoding.
package aes_sbox_sched_pkg;

  localparam int LANE_W    = 32;
  localparam int NUM_LANES = 4;
  localparam int STATE_W   = LANE_W * NUM_LANES;
  localparam int BEAT_W    = 2;
  localparam logic [BEAT_W-1:0] BEAT_LAST = 2'd3;

  // Key-schedule wait counter; saturates at KS_WAIT_MAX
  localparam int WAIT_W = 3;
  localparam logic [WAIT_W-1:0] KS_WAIT_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/aes_sbox_sched_sbox.sv
// AES forward S-box for one byte: multiplicative inverse in GF(2^8)
// (x^254, modulus 0x11b) followed by the standard affine transform.
module aes_sbox_sched_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] inv;

  // x -> x^3 -> x^7 ... x^127, then one squaring gives x^254 (0 maps to 0)
  always_comb begin
    inv = byte_i;
    for (int i = 0; i < 6; i++) inv = gf_mul(gf_mul(inv, inv), byte_i);
    inv = gf_mul(inv, inv);
    byte_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_sbox_sched.sv
// One 32-bit S-box lane shared between a 128-bit SubBytes state (four beats)
// and single-word key-schedule substitutions.
//
// state | meaning
// IDLE  | st_ready high, bank free for key schedule
// SUB   | substituting state word[beat], bank shared with key schedule
// HOLD  | result held on out_data until out_ready, bank free for key schedule
module aes_sbox_sched
  import aes_sbox_sched_pkg::*;
#(
  parameter int KS_PRIO = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [STATE_W-1:0] st_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  input  logic               ks_req,
  input  logic [LANE_W-1:0]  ks_word,
  output logic               ks_gnt,
  output logic               ks_valid,
  output logic [LANE_W-1:0]  ks_result
);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                last_gnt_q;
  logic [WAIT_W-1:0]   ks_wait_q, ks_wait_d;
  logic [STATE_W-1:0]  out_data_q, out_data_d;
  logic [LANE_W-1:0]   ks_result_q;
  logic                ks_valid_q;
  logic                gnt;
  logic [LANE_W-1:0]   bank_in;
  logic [LANE_W-1:0]   bank_out;

  always_comb begin : arbitrate
    gnt = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: gnt = ks_req;
      ST_SUB: begin
        if (ks_req) begin
          if (KS_PRIO != 0) gnt = ~last_gnt_q;
          else              gnt = (ks_wait_q >= KS_WAIT_MAX);
        end
      end
      default: gnt = 1'b0;
    endcase
  end

  // out_data_q holds the latched state and is overwritten word by word
  assign bank_in = gnt ? ks_word : out_data_q[int'(beat_q)*LANE_W +: LANE_W];

  for (genvar g = 0; g < LANE_W / 8; g++) begin : g_sbox
    aes_sbox_sched_sbox u_sbox (
      .byte_i(bank_in[8*g +: 8]),
      .byte_o(bank_out[8*g +: 8])
    );
  end

  always_comb begin : next_state
    state_d    = state_q;
    beat_d     = beat_q;
    out_data_d = out_data_q;
    ks_wait_d  = '0;
    if (ks_req && !gnt) begin
      ks_wait_d = (ks_wait_q == KS_WAIT_MAX) ? ks_wait_q : ks_wait_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (st_valid) begin
          state_d    = ST_SUB;
          beat_d     = '0;
          out_data_d = st_data;
        end
      end
      ST_SUB: begin
        if (!gnt) begin
          out_data_d[int'(beat_q)*LANE_W +: LANE_W] = bank_out;
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_LAST) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      last_gnt_q  <= 1'b0;
      ks_wait_q   <= '0;
      out_data_q  <= '0;
      ks_result_q <= '0;
      ks_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_gnt_q <= gnt;
      ks_wait_q  <= ks_wait_d;
      out_data_q <= out_data_d;
      ks_valid_q <= gnt;
      if (gnt) ks_result_q <= bank_out;
    end
  end

  assign st_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign ks_gnt    = gnt;
  assign ks_valid  = ks_valid_q;
  assign ks_result = ks_result_q;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Self-checking bench for aes_sbox_sched: table-based S-box reference model,
// randomized states and key-schedule words, one task per scenario.
module tb_aes_sbox_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         st_valid = 1'b0;
  logic         st_ready;
  logic [127:0] st_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         ks_req = 1'b0;
  logic [31:0]  ks_word = '0;
  logic         ks_gnt;
  logic         ks_valid;
  logic [31:0]  ks_result;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_hold;

  always #5 clk = ~clk;

  aes_sbox_sched #(.KS_PRIO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ks_req(ks_req), .ks_word(ks_word), .ks_gnt(ks_gnt),
    .ks_valid(ks_valid), .ks_result(ks_result)
  );

  logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stimulus only: offer a state with no key-schedule traffic, return the
  // cycles from accept to out_valid and the delivered data, then hand-shake.
  task automatic send_state(input logic [127:0] d, output int lat, output logic [127:0] got);
    @(posedge clk); #1;
    st_valid = 1'b1;
    st_data  = d;
    @(posedge clk); #1;
    st_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (st_ready !== 1'b1)  begin errors++; $display("FAIL reset_st_ready: got %b exp 1", st_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (ks_valid !== 1'b0)  begin errors++; $display("FAIL reset_ks_valid: got %b exp 0", ks_valid); end
    checks++; if (ks_gnt !== 1'b0)    begin errors++; $display("FAIL reset_ks_gnt: got %b exp 0", ks_gnt); end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
    checks++; if (ks_result !== '0)   begin errors++; $display("FAIL reset_ks_result: got %h exp 0", ks_result); end
    #9 rst_n = 1'b1;
  endtask

  task automatic test_zero_state();
    int lat;
    logic [127:0] got;
    send_state('0, lat, got);
    checks++; if (lat !== 4) begin errors++; $display("FAIL zero_latency: got %0d exp 4", lat); end
    checks++; if (got !== sub_state('0)) begin errors++; $display("FAIL zero_data: got %h exp %h", got, sub_state('0)); end
    checks++; if (st_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL zero_return_idle: got st_ready=%b out_valid=%b exp 1/0", st_ready, out_valid);
    end
  endtask

  task automatic test_known_word();
    int lat;
    logic [127:0] d, got;
    d = {$urandom(), $urandom(), $urandom(), 32'hff530100};
    send_state(d, lat, got);
    checks++; if (got[31:0] !== 32'h16ed7c63) begin errors++; $display("FAIL word0_vector: got %h exp 16ed7c63", got[31:0]); end
    checks++; if (got !== sub_state(d)) begin errors++; $display("FAIL word0_state: got %h exp %h", got, sub_state(d)); end
  endtask

  task automatic test_random_states();
    int lat;
    logic [127:0] d, got;
    for (int i = 0; i < 6; i++) begin
      d = rand128();
      send_state(d, lat, got);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rand_latency[%0d]: got %0d exp 4", i, lat); end
      checks++; if (got !== sub_state(d)) begin errors++; $display("FAIL rand_data[%0d]: got %h exp %h", i, got, sub_state(d)); end
    end
  endtask

  task automatic test_ks_idle();
    logic [31:0] w;
    @(posedge clk); #1;
    ks_req  = 1'b1;
    ks_word = 32'h01c2a3ff;
    #1;
    checks++; if (ks_gnt !== 1'b1) begin errors++; $display("FAIL ks_idle_gnt: got %b exp 1", ks_gnt); end
    @(posedge clk); #1;
    ks_req = 1'b0;
    checks++; if (ks_valid !== 1'b1) begin errors++; $display("FAIL ks_idle_valid: got %b exp 1", ks_valid); end
    checks++; if (ks_result !== 32'h7c250a16) begin errors++; $display("FAIL ks_idle_result: got %h exp 7c250a16", ks_result); end
    // back-to-back grants in IDLE
    for (int i = 0; i < 4; i++) begin
      w = $urandom();
      ks_req  = 1'b1;
      ks_word = w;
      #1;
      checks++; if (ks_gnt !== 1'b1) begin errors++; $display("FAIL ks_b2b_gnt[%0d]: got %b exp 1", i, ks_gnt); end
      @(posedge clk); #1;
      checks++; if (ks_valid !== 1'b1 || ks_result !== sub_word(w)) begin
        errors++; $display("FAIL ks_b2b_result[%0d]: got v=%b %h exp v=1 %h", i, ks_valid, ks_result, sub_word(w));
      end
    end
    ks_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL ks_b2b_end: got %b exp 0", ks_valid); end
  endtask

  // ks_req held high from the accept cycle: SUB alternates beat / ks grant,
  // so the seven SUB cycles are beat,ks,beat,ks,beat,ks,beat.
  task automatic test_contention();
    logic [127:0] d;
    logic [31:0]  w, prev_w;
    logic         prev_g, exp_g;
    int           n;
    d = rand128();
    @(posedge clk); #1;
    w = $urandom();
    ks_word  = w;
    ks_req   = 1'b1;
    st_data  = d;
    st_valid = 1'b1;
    #1;
    checks++; if (ks_gnt !== 1'b1 || st_ready !== 1'b1) begin
      errors++; $display("FAIL cont_accept: got gnt=%b st_ready=%b exp 1/1", ks_gnt, st_ready);
    end
    prev_g = 1'b1;
    prev_w = w;
    n = -1;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      st_valid = 1'b0;
      checks++; if (ks_valid !== prev_g) begin errors++; $display("FAIL cont_ks_valid[%0d]: got %b exp %b", n, ks_valid, prev_g); end
      if (prev_g) begin
        checks++; if (ks_result !== sub_word(prev_w)) begin
          errors++; $display("FAIL cont_ks_result[%0d]: got %h exp %h", n, ks_result, sub_word(prev_w));
        end
        w = $urandom();
        ks_word = w;
      end
      #1;
      if (out_valid) break;
      exp_g = n[0];
      checks++; if (ks_gnt !== exp_g) begin errors++; $display("FAIL cont_gnt[%0d]: got %b exp %b", n, ks_gnt, exp_g); end
      prev_g = exp_g;
      prev_w = ks_word;
    end
    checks++; if (n !== 7) begin errors++; $display("FAIL cont_latency: got %0d exp 7", n); end
    exp_hold = sub_state(d);
    checks++; if (out_data !== exp_hold) begin errors++; $display("FAIL cont_data: got %h exp %h", out_data, exp_hold); end
    checks++; if (ks_gnt !== 1'b1) begin errors++; $display("FAIL cont_hold_gnt: got %b exp 1", ks_gnt); end
  endtask

  // Continues from test_contention: DUT in HOLD, ks_req still high.
  task automatic test_hold_backpressure();
    logic [31:0] prev_w;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_hold) begin
        errors++; $display("FAIL hold_data[%0d]: got v=%b %h exp v=1 %h", i, out_valid, out_data, exp_hold);
      end
      checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL hold_st_ready[%0d]: got %b exp 0", i, st_ready); end
      checks++; if (ks_gnt !== 1'b1) begin errors++; $display("FAIL hold_gnt[%0d]: got %b exp 1", i, ks_gnt); end
      prev_w = ks_word;
      @(posedge clk); #1;
      checks++; if (ks_valid !== 1'b1 || ks_result !== sub_word(prev_w)) begin
        errors++; $display("FAIL hold_ks[%0d]: got v=%b %h exp v=1 %h", i, ks_valid, ks_result, sub_word(prev_w));
      end
      ks_word = $urandom();
      #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (st_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL hold_handshake: got st_ready=%b out_valid=%b exp 0/1", st_ready, out_valid);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    ks_req    = 1'b0;
    #1;
    checks++; if (st_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: got st_ready=%b out_valid=%b exp 1/0", st_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [127:0] d, got;
    d = rand128();
    @(posedge clk); #1;
    st_valid = 1'b1;
    st_data  = d;
    @(posedge clk); #1;
    st_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    ks_req  = 1'b1;
    ks_word = $urandom();
    #1;
    checks++; if (ks_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b exp 1", ks_gnt); end
    rst_n  = 1'b0;
    ks_req = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || ks_valid !== 1'b0 || ks_gnt !== 1'b0) begin
      errors++; $display("FAIL rmid_ctrl: got out_valid=%b ks_valid=%b ks_gnt=%b exp 0/0/0", out_valid, ks_valid, ks_gnt);
    end
    checks++; if (out_data !== '0 || ks_result !== '0) begin
      errors++; $display("FAIL rmid_data: got %h / %h exp 0", out_data, ks_result);
    end
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rmid_st_ready: got %b exp 1", st_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || ks_valid !== 1'b0) begin
        errors++; $display("FAIL rmid_ghost[%0d]: got out_valid=%b ks_valid=%b exp 0/0", i, out_valid, ks_valid);
      end
    end
    d = rand128();
    send_state(d, lat, got);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rmid_after_latency: got %0d exp 4", lat); end
    checks++; if (got !== sub_state(d)) begin errors++; $display("FAIL rmid_after_data: got %h exp %h", got, sub_state(d)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_state();
    test_known_word();
    test_random_states();
    test_ks_idle();
    test_contention();
    test_hold_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_sbox_sched.md
AES_SBOX_SCHED -- requirements
Module: aes_sbox_sched

Interface
REQ-001 SHALL have parameter: KS_PRIO, default 1, 1 = key-schedule requester wins contention (with anti-starvation), 0 = state requester wins.
REQ-002 SHALL have port: clk  input  1  single clock; all registers on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: st_valid  input  1  128-bit state offered for SubBytes.
REQ-005 SHALL have port: st_ready  output  1  block accepts a state this cycle.
REQ-006 SHALL have port: st_data  input  128  state in; word k = st_data[32k+31:32k], k=0..3.
REQ-007 SHALL have port: out_valid  output  1  substituted state available.
REQ-008 SHALL have port: out_ready  input  1  consumer takes out_data.
REQ-009 SHALL have port: out_data  output  128  substituted state, same byte positions as st_data.
REQ-010 SHALL have port: ks_req  input  1  key-schedule requests one 32-bit substitution.
REQ-011 SHALL have port: ks_word  input  32  key-schedule word; held stable while ks_req is high and ks_gnt is low.
REQ-012 SHALL have port: ks_gnt  output  1  combinational grant of the S-box bank to the key schedule this cycle.
REQ-013 SHALL have port: ks_valid  output  1  one-cycle pulse, ks_result valid.
REQ-014 SHALL have port: ks_result  output  32  SubWord(ks_word) from the granted cycle.

Function
REQ-015 SHALL own one shared bank of four byte S-boxes (one 32-bit lane); each byte maps through the standard AES forward S-box (00->63, 01->7c, 53->ed, ff->16).
REQ-016 SHALL implement states IDLE, SUB, HOLD; a 2-bit beat counter beat counts 0..3 in SUB.
REQ-017 SHALL drive st_ready = 1 only in IDLE.
REQ-018 SHALL go IDLE->SUB on st_valid&&st_ready, latching st_data and setting beat=0.
REQ-019 SHALL, in each SUB cycle where the bank is given to the state, substitute word[beat] into out_data[32*beat+31:32*beat] and increment beat.
REQ-020 SHALL go SUB->HOLD on the edge that stores beat 3, so that out_valid rises 4 cycles after the accept edge if there is no contention.
REQ-021 SHALL hold out_valid and out_data stable in HOLD until out_valid&&out_ready, then return to IDLE; st_ready SHALL stay low during that handshake cycle.
REQ-022 SHALL grant ks_req immediately in IDLE and in HOLD.
REQ-023 SHALL arbitrate contention in SUB with KS_PRIO=1 as follows: grant ks unless ks was granted in the previous cycle.
REQ-024 SHALL arbitrate contention in SUB with KS_PRIO=0 as follows: grant ks only in the cycle after SUB->HOLD, or when ks has waited 4 cycles.
REQ-025 SHALL freeze beat and data in a SUB cycle where the bank goes to ks; no beat SHALL be lost or repeated.
REQ-026 SHALL register ks_result and pulse ks_valid on the cycle after ks_gnt; back-to-back grants in IDLE/HOLD SHALL give back-to-back ks_valid pulses.
REQ-027 SHALL never let ks_gnt and a state beat use the bank in the same cycle.

Reset
REQ-028 SHALL, on rst_n low (async), force state=IDLE, beat=0, last-grant flag=0, out_data=0, ks_result=0, out_valid=0, ks_valid=0; st_ready and ks_gnt then follow the IDLE rules.
REQ-029 SHALL discard any in-flight state or key-schedule request on reset mid-operation; no out_valid or ks_valid SHALL follow from a request that was pending before reset.

Structure
REQ-030 SHALL take state encodings, beat width and the lane width (32) from the shared AES package.
REQ-031 SHALL instantiate the existing byte S-box module four times as the only sub-module; no local S-box table.

Verification
REQ-032 SHALL cover: st_data=128'h0, no ks -> out_valid 4 cycles after accept, out_data=128'h6363...63.
REQ-033 SHALL cover: ks_req with ks_word=32'h01c2a3ff in IDLE -> ks_gnt same cycle, next cycle ks_valid=1 and ks_result=32'h7c250a16.
REQ-034 SHALL cover: ks_req held high during SUB with KS_PRIO=1 -> grants alternate with state beats, out_valid 7 cycles after accept, data correct.
REQ-035 SHALL cover: out_ready low 5 cycles in HOLD -> out_data stable, st_ready=0, ks still granted; one out_ready cycle returns to IDLE.
REQ-036 SHALL cover: rst_n pulsed low at beat 2 -> all outputs 0 immediately; a new state after reset yields a correct result.
REQ-037 SHALL cover: st_data word0=32'hff530100 -> out_data word0=32'h16ed7c63.
